// File: rtl/spec_key_decoder_if.sv
// Scan-code input and key-event output bundle for spec_key_decoder.
//   SCAN_CODE/SCAN_VALID : byte and one-cycle qualifier from the PS/2 receiver
//   END_OF_LINE, BACKSPACE, ESCAPE, TAB : one-cycle key-make pulses
//   KEY_HELD       : held level per key {TAB,ESC,BS,ENTER}
//   PREFIX_TIMEOUT : one-cycle pulse when a pending prefix is abandoned
interface spec_key_decoder_if;
  logic [7:0] SCAN_CODE;
  logic       SCAN_VALID;
  logic       END_OF_LINE;
  logic       BACKSPACE;
  logic       ESCAPE;
  logic       TAB;
  logic [3:0] KEY_HELD;
  logic       PREFIX_TIMEOUT;

  modport master (
    output SCAN_CODE, SCAN_VALID,
    input  END_OF_LINE, BACKSPACE, ESCAPE, TAB, KEY_HELD, PREFIX_TIMEOUT
  );

  modport slave (
    input  SCAN_CODE, SCAN_VALID,
    output END_OF_LINE, BACKSPACE, ESCAPE, TAB, KEY_HELD, PREFIX_TIMEOUT
  );
endinterface

// File: rtl/spec_key_decoder.sv
// PS/2 set-2 special-key decoder: tracks E0/F0 prefixes and turns makes and
// breaks of Enter, BackSpace, Esc and Tab into registered pulses and held levels.
//   CLK     : the only clock, rising edge
//   RESET_N : asynchronous active-low reset, deassertion synchronised internally
//   kb      : slave side of spec_key_decoder_if (scan input, key-event outputs)
module spec_key_decoder #(
  parameter logic [7:0]  ENTER_CODE     = 8'h5A,
  parameter logic [7:0]  BACKSPACE_CODE = 8'h66,
  parameter logic [7:0]  ESCAPE_CODE    = 8'h76,
  parameter logic [7:0]  TAB_CODE       = 8'h0D,
  parameter bit          EXT_ENTER_EN   = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input logic              CLK,
  input logic              RESET_N,
  spec_key_decoder_if.slave kb
);

  localparam int unsigned CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [7:0]  PFX_EXT = 8'hE0;
  localparam logic [7:0]  PFX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  // Reset synchroniser: asserts immediately, releases after two CLK edges.
  logic [1:0] rst_sync;
  logic       rst_int_n;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n = rst_sync[1];

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       held_q, held_d;
  logic             eol_q, bs_q, esc_q, tab_q, pto_q;
  logic             eol_c, bs_c, esc_c, tab_c, pto_c;
  logic             is_make_c, is_break_c, is_ext_c;

  // Prefix tracking, timeout and key decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    held_d     = held_q;
    eol_c      = 1'b0;
    bs_c       = 1'b0;
    esc_c      = 1'b0;
    tab_c      = 1'b0;
    pto_c      = 1'b0;
    is_make_c  = 1'b0;
    is_break_c = 1'b0;
    is_ext_c   = 1'b0;

    if (kb.SCAN_VALID) begin
      // A valid byte always wins over a coincident timeout.
      cnt_d = '0;
      case (state_q)
        S_IDLE: begin
          if (kb.SCAN_CODE == PFX_EXT)      state_d = S_EXT;
          else if (kb.SCAN_CODE == PFX_BRK) state_d = S_BRK;
          else begin
            is_make_c = 1'b1;
            state_d   = S_IDLE;
          end
        end
        S_EXT: begin
          if (kb.SCAN_CODE == PFX_EXT)      state_d = S_EXT;
          else if (kb.SCAN_CODE == PFX_BRK) state_d = S_EXT_BRK;
          else begin
            is_make_c = 1'b1;
            is_ext_c  = 1'b1;
            state_d   = S_IDLE;
          end
        end
        S_BRK: begin
          // Repeated F0 is malformed; keep waiting for the break byte.
          if (kb.SCAN_CODE == PFX_BRK) state_d = S_BRK;
          else begin
            is_break_c = 1'b1;
            state_d    = S_IDLE;
          end
        end
        default: begin
          if (kb.SCAN_CODE == PFX_BRK) state_d = S_BRK;
          else begin
            is_break_c = 1'b1;
            is_ext_c   = 1'b1;
            state_d    = S_IDLE;
          end
        end
      endcase
    end else if (state_q != S_IDLE) begin
      if (cnt_q == CNT_MAX) begin
        state_d = S_IDLE;
        cnt_d   = '0;
        pto_c   = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end

    // Else-if chains keep the pulses mutually exclusive even with aliased codes.
    if (is_make_c && !is_ext_c) begin
      if (kb.SCAN_CODE == ENTER_CODE) begin
        eol_c = 1'b1;
        held_d[0] = 1'b1;
      end else if (kb.SCAN_CODE == BACKSPACE_CODE) begin
        bs_c = 1'b1;
        held_d[1] = 1'b1;
      end else if (kb.SCAN_CODE == ESCAPE_CODE) begin
        esc_c = 1'b1;
        held_d[2] = 1'b1;
      end else if (kb.SCAN_CODE == TAB_CODE) begin
        tab_c = 1'b1;
        held_d[3] = 1'b1;
      end
    end else if (is_make_c && EXT_ENTER_EN && kb.SCAN_CODE == ENTER_CODE) begin
      eol_c = 1'b1;
      held_d[0] = 1'b1;
    end

    if (is_break_c && !is_ext_c) begin
      if (kb.SCAN_CODE == ENTER_CODE)          held_d[0] = 1'b0;
      else if (kb.SCAN_CODE == BACKSPACE_CODE) held_d[1] = 1'b0;
      else if (kb.SCAN_CODE == ESCAPE_CODE)    held_d[2] = 1'b0;
      else if (kb.SCAN_CODE == TAB_CODE)       held_d[3] = 1'b0;
    end else if (is_break_c && EXT_ENTER_EN && kb.SCAN_CODE == ENTER_CODE) begin
      held_d[0] = 1'b0;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge CLK or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      held_q  <= 4'b0000;
      eol_q   <= 1'b0;
      bs_q    <= 1'b0;
      esc_q   <= 1'b0;
      tab_q   <= 1'b0;
      pto_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
      eol_q   <= eol_c;
      bs_q    <= bs_c;
      esc_q   <= esc_c;
      tab_q   <= tab_c;
      pto_q   <= pto_c;
    end
  end

  assign kb.END_OF_LINE    = eol_q;
  assign kb.BACKSPACE      = bs_q;
  assign kb.ESCAPE         = esc_q;
  assign kb.TAB            = tab_q;
  assign kb.KEY_HELD       = held_q;
  assign kb.PREFIX_TIMEOUT = pto_q;

endmodule

// File: tb/tb_spec_key_decoder.sv
// Directed scoreboard bench for spec_key_decoder: dut_a with keypad Enter
// enabled, dut_b with it disabled, both with a short prefix timeout.
module tb_spec_key_decoder;

  localparam int unsigned TO = 20;

  localparam logic [3:0] P_NONE = 4'b0000;
  localparam logic [3:0] P_EOL  = 4'b0001;
  localparam logic [3:0] P_BS   = 4'b0010;
  localparam logic [3:0] P_ESC  = 4'b0100;
  localparam logic [3:0] P_TAB  = 4'b1000;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;
  logic [8:0] exp_q[$];

  spec_key_decoder_if kb_a ();
  spec_key_decoder_if kb_b ();

  spec_key_decoder #(.EXT_ENTER_EN(1'b1), .TIMEOUT_CYCLES(TO)) dut_a (
    .CLK(clk), .RESET_N(rst_n), .kb(kb_a.slave)
  );

  spec_key_decoder #(.EXT_ENTER_EN(1'b0), .TIMEOUT_CYCLES(TO)) dut_b (
    .CLK(clk), .RESET_N(rst_n), .kb(kb_b.slave)
  );

  // {PREFIX_TIMEOUT, KEY_HELD, TAB, ESCAPE, BACKSPACE, END_OF_LINE}
  logic [8:0] out_a, out_b;
  assign out_a = {kb_a.PREFIX_TIMEOUT, kb_a.KEY_HELD, kb_a.TAB, kb_a.ESCAPE,
                  kb_a.BACKSPACE, kb_a.END_OF_LINE};
  assign out_b = {kb_b.PREFIX_TIMEOUT, kb_b.KEY_HELD, kb_b.TAB, kb_b.ESCAPE,
                  kb_b.BACKSPACE, kb_b.END_OF_LINE};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] ex(input logic pto, input logic [3:0] held,
                                    input logic [3:0] pulse);
    return {pto, held, pulse};
  endfunction

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // One clock of stimulus on the selected DUT; result compared after the edge.
  task automatic step(input bit sel_b, input logic vld, input logic [7:0] code,
                      input logic [8:0] e, input string tag);
    exp_q.push_back(e);
    @(negedge clk);
    if (sel_b) begin
      kb_b.SCAN_VALID = vld;
      kb_b.SCAN_CODE  = code;
    end else begin
      kb_a.SCAN_VALID = vld;
      kb_a.SCAN_CODE  = code;
    end
    @(posedge clk);
    #1;
    kb_a.SCAN_VALID = 1'b0;
    kb_b.SCAN_VALID = 1'b0;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_err++;
      $error("FAIL %s: observed=empty-queue expected=entry", tag);
    end else begin
      chk(tag, sel_b ? out_b : out_a, exp_q.pop_front());
    end
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    kb_a.SCAN_VALID = 1'b0;
    kb_a.SCAN_CODE  = 8'h00;
    kb_b.SCAN_VALID = 1'b0;
    kb_b.SCAN_CODE  = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_a", out_a, 9'b0);
    chk("reset_b", out_b, 9'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Enter make / break
    step(0, 1, 8'h5A, ex(0, 4'b0001, P_EOL),  "enter_make");
    step(0, 0, 8'h00, ex(0, 4'b0001, P_NONE), "enter_pulse_end");
    step(0, 1, 8'hF0, ex(0, 4'b0001, P_NONE), "enter_brk_pfx");
    step(0, 1, 8'h5A, ex(0, 4'b0000, P_NONE), "enter_break");

    // Keypad Enter, enabled
    step(0, 1, 8'hE0, ex(0, 4'b0000, P_NONE), "kp_enter_pfx");
    step(0, 1, 8'h5A, ex(0, 4'b0001, P_EOL),  "kp_enter_make");
    step(0, 1, 8'hE0, ex(0, 4'b0001, P_NONE), "kp_enter_e0");
    step(0, 1, 8'hF0, ex(0, 4'b0001, P_NONE), "kp_enter_f0");
    step(0, 1, 8'h5A, ex(0, 4'b0000, P_NONE), "kp_enter_break");

    // Extended make of a non-Enter code is ignored
    step(0, 1, 8'hE0, ex(0, 4'b0000, P_NONE), "ext_bs_pfx");
    step(0, 1, 8'h66, ex(0, 4'b0000, P_NONE), "ext_bs_make");

    // Keypad Enter, disabled
    step(1, 1, 8'h5A, ex(0, 4'b0001, P_EOL),  "b_enter_make");
    step(1, 1, 8'hE0, ex(0, 4'b0001, P_NONE), "b_kp_pfx");
    step(1, 1, 8'h5A, ex(0, 4'b0001, P_NONE), "b_kp_make");
    step(1, 1, 8'hE0, ex(0, 4'b0001, P_NONE), "b_kp_e0");
    step(1, 1, 8'hF0, ex(0, 4'b0001, P_NONE), "b_kp_f0");
    step(1, 1, 8'h5A, ex(0, 4'b0001, P_NONE), "b_kp_break");

    // Typematic BackSpace
    for (int i = 0; i < 3; i++)
      step(0, 1, 8'h66, ex(0, 4'b0010, P_BS), $sformatf("bs_typematic_%0d", i));
    step(0, 1, 8'hF0, ex(0, 4'b0010, P_NONE), "bs_brk_pfx");
    step(0, 1, 8'h66, ex(0, 4'b0000, P_NONE), "bs_break");

    // Esc with malformed double F0 before its break
    step(0, 1, 8'h76, ex(0, 4'b0100, P_ESC),  "esc_make");
    step(0, 1, 8'hF0, ex(0, 4'b0100, P_NONE), "esc_f0_1");
    step(0, 1, 8'hF0, ex(0, 4'b0100, P_NONE), "esc_f0_2");
    step(0, 1, 8'h76, ex(0, 4'b0000, P_NONE), "esc_break");

    // Unlisted code and a byte without SCAN_VALID
    step(0, 1, 8'h1C, ex(0, 4'b0000, P_NONE), "unlisted_1c");
    step(0, 0, 8'h0D, ex(0, 4'b0000, P_NONE), "tab_not_valid");

    // Tab, extended break of Tab ignored, then real break
    step(0, 1, 8'h0D, ex(0, 4'b1000, P_TAB),  "tab_make");
    step(0, 1, 8'hE0, ex(0, 4'b1000, P_NONE), "tab_ext_e0");
    step(0, 1, 8'hF0, ex(0, 4'b1000, P_NONE), "tab_ext_f0");
    step(0, 1, 8'h0D, ex(0, 4'b1000, P_NONE), "tab_ext_break");
    step(0, 1, 8'hF0, ex(0, 4'b1000, P_NONE), "tab_brk_pfx");
    step(0, 1, 8'h0D, ex(0, 4'b0000, P_NONE), "tab_break");

    // Abandoned break prefix
    step(0, 1, 8'hF0, ex(0, 4'b0000, P_NONE), "to_pfx");
    for (int i = 0; i < int'(TO); i++)
      step(0, 0, 8'h00, ex(0, 4'b0000, P_NONE), $sformatf("to_wait_%0d", i));
    step(0, 0, 8'h00, ex(1, 4'b0000, P_NONE), "to_pulse");
    step(0, 0, 8'h00, ex(0, 4'b0000, P_NONE), "to_pulse_end");
    step(0, 1, 8'h76, ex(0, 4'b0100, P_ESC),  "to_then_esc_make");

    // Byte arriving on the timeout cycle is decoded as the pending break
    step(0, 1, 8'hF0, ex(0, 4'b0100, P_NONE), "prio_pfx");
    for (int i = 0; i < int'(TO); i++)
      step(0, 0, 8'h00, ex(0, 4'b0100, P_NONE), $sformatf("prio_wait_%0d", i));
    step(0, 1, 8'h76, ex(0, 4'b0000, P_NONE), "prio_esc_break");
    step(0, 0, 8'h00, ex(0, 4'b0000, P_NONE), "prio_no_timeout");

    // Reset in the middle of an E0 F0 sequence
    step(0, 1, 8'h5A, ex(0, 4'b0001, P_EOL),  "rst_setup_enter");
    step(0, 1, 8'hE0, ex(0, 4'b0001, P_NONE), "rst_e0");
    step(0, 1, 8'hF0, ex(0, 4'b0001, P_NONE), "rst_f0");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_async_clear", out_a, 9'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_held_low", out_a, 9'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++)
      step(0, 0, 8'h00, ex(0, 4'b0000, P_NONE), $sformatf("rst_release_%0d", i));
    step(0, 1, 8'h0D, ex(0, 4'b1000, P_TAB),  "rst_then_tab_make");
    step(0, 0, 8'h00, ex(0, 4'b1000, P_NONE), "rst_tab_pulse_end");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/spec_key_decoder.md
SPEC_KEY_DECODER -- requirements
Module: spec_key_decoder

Interface
REQ-001 SHALL have parameter ENTER_CODE, default 8'h5A, meaning Enter make code.
REQ-002 SHALL have parameter BACKSPACE_CODE, default 8'h66, meaning BackSpace make code.
REQ-003 SHALL have parameter ESCAPE_CODE, default 8'h76, meaning Esc make code.
REQ-004 SHALL have parameter TAB_CODE, default 8'h0D, meaning Tab make code.
REQ-005 SHALL have parameter EXT_ENTER_EN, default 1, meaning keypad Enter (E0 5A) also counts as Enter.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000, meaning prefix abandon limit in CLK cycles (>=2).
REQ-007 SHALL have port CLK, input, 1, the only clock; all logic on its rising edge.
REQ-008 SHALL have port RESET_N, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port SCAN_CODE, input, 8, byte from the PS/2 interface.
REQ-010 SHALL have port SCAN_VALID, input, 1, one-cycle strobe qualifying SCAN_CODE.
REQ-011 SHALL have port END_OF_LINE, output, 1, one-cycle pulse on an Enter make.
REQ-012 SHALL have port BACKSPACE, output, 1, one-cycle pulse on a BackSpace make.
REQ-013 SHALL have port ESCAPE, output, 1, one-cycle pulse on an Esc make.
REQ-014 SHALL have port TAB, output, 1, one-cycle pulse on a Tab make.
REQ-015 SHALL have port KEY_HELD, output, 4, level per key {TAB,ESC,BS,ENTER}, bit0 = Enter.
REQ-016 SHALL have port PREFIX_TIMEOUT, output, 1, one-cycle pulse when a pending prefix is abandoned.

Function
REQ-017 SHALL implement FSM states IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
REQ-018 SHALL apply these transitions on SCAN_VALID only: IDLE+E0->EXT; IDLE+F0->BRK; EXT+F0->EXT_BRK; EXT+E0 stays EXT; any other byte in any state ->IDLE after decode.
REQ-019 SHALL treat a byte in IDLE as a normal make, in EXT as an extended make, in BRK as a normal break, and in EXT_BRK as an extended break.
REQ-020 SHALL register all outputs; a pulse appears in the cycle after the SCAN_VALID cycle carrying the final byte (latency 1).
REQ-021 SHALL pulse the matching key output on a normal make, including typematic repeats (every make pulses, whether or not the key is already held).
REQ-022 SHALL pulse END_OF_LINE on an extended make of ENTER_CODE only when EXT_ENTER_EN=1; other extended makes produce no pulse.
REQ-023 SHALL set the KEY_HELD bit on the qualifying make and clear it on the matching break (normal break; extended break of Enter only when EXT_ENTER_EN=1), with the update visible one cycle after SCAN_VALID.
REQ-024 SHALL ignore breaks and makes of non-listed codes (no pulse, no KEY_HELD change), and return to IDLE.
REQ-025 SHALL treat F0 received in BRK or EXT_BRK as a malformed sequence: stay in BRK, no output.
REQ-026 SHALL run a timeout counter, clamped to ceil(log2(TIMEOUT_CYCLES+1)) bits, that clears on every SCAN_VALID and counts while the state is not IDLE.
REQ-027 SHALL return to IDLE and pulse PREFIX_TIMEOUT for one cycle when the counter reaches TIMEOUT_CYCLES, leaving KEY_HELD unchanged.
REQ-028 SHALL give SCAN_VALID priority when it coincides with the timeout cycle: decode the byte in the current state, with no PREFIX_TIMEOUT.
REQ-029 SHALL hold the counter at 0 in IDLE, so it never wraps.
REQ-030 SHALL never assert more than one of END_OF_LINE, BACKSPACE, ESCAPE, TAB in the same cycle.
REQ-031 SHALL ignore SCAN_CODE entirely while SCAN_VALID=0.

Reset
REQ-032 SHALL, while RESET_N=0, immediately force state IDLE, counter 0, and all outputs 0 (KEY_HELD=4'b0000).
REQ-033 SHALL discard any partial prefix when reset is asserted mid-sequence; the first byte after release is decoded from IDLE.
REQ-034 SHALL synchronise RESET_N deassertion to CLK before release (two-flop).

Verification
REQ-035 SHALL be checked for: 5A -> END_OF_LINE=1 for one cycle and KEY_HELD=0001; then F0 5A -> no pulse and KEY_HELD=0000.
REQ-036 SHALL be checked for: E0 5A with EXT_ENTER_EN=1 -> END_OF_LINE pulse; repeated with EXT_ENTER_EN=0 -> no pulse and KEY_HELD unchanged.
REQ-037 SHALL be checked for: 66 66 66 (typematic) -> three BACKSPACE pulses and KEY_HELD[1]=1 throughout; then F0 66 -> KEY_HELD[1]=0.
REQ-038 SHALL be checked for: F0 followed by TIMEOUT_CYCLES idle cycles -> PREFIX_TIMEOUT pulse and state IDLE; a following 76 -> ESCAPE pulse, not a break.
REQ-039 SHALL be checked for: E0 F0, then RESET_N low for 3 cycles, then 0D -> TAB pulse and KEY_HELD=1000.
REQ-040 SHALL be checked for: a byte 1C, and 0D presented with SCAN_VALID=0 -> no outputs change.
